div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring integer divider for the RV32M DIV/DIVU/REM/REMU ops.
//  It is the inverse-operation partner of the pipelined multiplier in the integer
//  execute cluster, and sits on the same issue-to-writeback path. It takes one op
//  per valid/ready handshake and returns the quotient or remainder with its ROB tag.
//  The writeback arbiter can stall the result through out_ready. Flush kills the op.
// PARAMETERS
//  XLEN       32  operand/result width
//  TAG_WIDTH  6   ROB tag width carried alongside the op
// PORTS
//  clock      in   1          system clock, posedge
//  reset      in   1          asynchronous, active-high reset
//  flush      in   1          sync kill of in-flight op (branch mispredict)
//  in_valid   in   1          op presented
//  in_ready   out  1          divider can accept (state IDLE)
//  div_type   in   2          00 DIV, 01 DIVU, 10 REM, 11 REMU
//  in1        in   XLEN       dividend (rs1)
//  in2        in   XLEN       divisor (rs2)
//  in_tag     in   TAG_WIDTH  ROB tag of op
//  out_valid  out  1          result available
//  out_ready  in   1          writeback accepts result
//  out        out  XLEN       quotient (DIV/DIVU) or remainder (REM/REMU)
//  out_tag    out  TAG_WIDTH  tag of returned op
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-high.
//  Reset values: state IDLE, out_valid 0, out 0, out_tag 0. in_ready reads 1.
//  Handshakes:
//   - Accept on in_valid & in_ready at a rising edge; latch operands, type and tag.
//   - in_ready = (state==IDLE). No same-cycle bypass of a result into a new accept.
//  FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE -> CALC on accept of a normal op; iteration counter set to XLEN-1.
//   - CALC: one restoring step per cycle.
//     - {rem,quo} shifted left 1; trial = rem - |divisor|.
//     - If trial >= 0 (no borrow), rem = trial and quo LSB = 1.
//     - Leave CALC after exactly XLEN cycles (counter reaches 0).
//   - FIX: one cycle of sign correction; registered result loaded into out.
//   - DONE: out_valid=1; out and out_tag held stable until out_valid & out_ready.
//     Then go to IDLE (in_ready high the following cycle).
//  Latency: normal op gives out_valid XLEN+2 edges after the accept edge
//   (XLEN CALC cycles + FIX, then DONE).
//  Signed ops (DIV/REM):
//   - Operate on magnitudes.
//   - Quotient is negated iff the operand signs differ.
//   - Remainder takes the sign of the dividend.
//   - The magnitude of 0x80000000 is handled as unsigned 2^31 (no overflow internally).
//  Special cases go IDLE -> DONE directly; out_valid is set 1 edge after accept:
//   - divisor==0: quotient = all ones (DIV and DIVU); remainder = dividend.
//   - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000,
//     remainder 0.
//  Flush:
//   - Any state -> IDLE next edge; out_valid deasserts.
//   - flush has priority over in_valid: no accept in a flush cycle.
//   - flush in DONE with out_ready=1 in the same cycle: the result still counts as
//     taken, state goes to IDLE.
//  Reset mid-operation: immediate return to reset values; the in-flight op is lost.
//  Inputs in1/in2/div_type/in_tag are don't-care except in the accept cycle.
// TESTING
//  - DIV 100/7, tag 5 -> out_valid at edge +34: out=14, out_tag=5; REM same ops -> 2.
//  - DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9/2
//    -> 0x7FFFFFFC.
//  - DIVU 5/0 -> 0xFFFFFFFF at edge +1; REMU 5/0 -> 5; DIV 0x80000000/-1
//    -> 0x80000000; REM same ops -> 0.
//  - Back-pressure: out_ready low for 10 cycles in DONE -> out and out_tag stable,
//    in_ready 0; release -> one transfer, then in_ready 1.
//  - flush at edge +10 of a DIV -> out_valid never rises, in_ready=1 next cycle.
//    flush together with in_valid -> op not accepted.
//  - Async reset pulse mid-CALC (between edges) -> out_valid 0 and in_ready 1
//    immediately; a following DIVU 9/3 returns 3.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One op in flight: IDLE -> CALC (XLEN steps) -> FIX (sign correction) -> DONE.
module div_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           div_type,
  input  logic [XLEN-1:0]      in1,
  input  logic [XLEN-1:0]      in2,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic                 is_rem_q, is_rem_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [XLEN-1:0]      out_q, out_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

  logic                 is_signed, in1_neg, in2_neg, accept;
  logic [XLEN-1:0]      abs1, abs2;
  logic [XLEN:0]        shifted, trial;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign out_tag   = out_tag_q;

  assign is_signed = ~div_type[0];
  assign in1_neg   = is_signed & in1[XLEN-1];
  assign in2_neg   = is_signed & in2[XLEN-1];
  // Negating MIN_NEG yields itself, which read unsigned is exactly 2^(XLEN-1).
  assign abs1      = in1_neg ? -in1 : in1;
  assign abs2      = in2_neg ? -in2 : in2;
  assign accept    = in_valid & in_ready & ~flush;

  // Partial remainder is always below the divisor, so the shifted value fits
  // XLEN+1 bits and bit XLEN of the difference is the borrow.
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign trial     = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    tag_d     = tag_q;
    out_d     = out_q;
    out_tag_d = out_tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_d     = in_tag;
          is_rem_d  = div_type[1];
          neg_quo_d = in1_neg ^ in2_neg;
          neg_rem_d = in1_neg;
          if (in2 == '0) begin
            out_d     = div_type[1] ? in1 : '1;
            out_tag_d = in_tag;
            state_d   = S_DONE;
          end else if (is_signed && in1 == MIN_NEG && in2 == '1) begin
            out_d     = div_type[1] ? '0 : MIN_NEG;
            out_tag_d = in_tag;
            state_d   = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = abs1;
            dvs_d   = abs2;
            cnt_d   = CNT_W'(XLEN-1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_rem_q) out_d = neg_rem_q ? -rem_q : rem_q;
        else          out_d = neg_quo_q ? -quo_q : quo_q;
        out_tag_d = tag_q;
        state_d   = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      tag_q     <= '0;
      out_q     <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      tag_q     <= tag_d;
      out_q     <= out_d;
      out_tag_q <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected result/tag/latency queued at issue,
// popped and checked when out_valid appears.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  div_type;
  logic [31:0] in1, in2;
  logic [5:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [5:0]  out_tag;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  div_unit #(.XLEN(32), .TAG_WIDTH(6)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .div_type(div_type),
    .in1(in1), .in2(in2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Latency n counts edges from the accept edge: n=1 means valid right after it.
  task automatic wait_result(input string name);
    exp_t e;
    int   n;
    n = 1;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check({name, " queue"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({name, " latency"}, 32'(n), 32'(e.lat));
      check({name, " out"}, out, e.res);
      check({name, " tag"}, 32'(out_tag), 32'(e.tag));
    end
  endtask

  task automatic consume(input string name);
    @(posedge clock); #1;
    check({name, " valid_drop"}, 32'(out_valid), 32'd0);
    check({name, " ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] dt, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag);
    @(negedge clock);
    check("in_ready_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1; div_type = dt; in1 = a; in2 = b; in_tag = tag;
    @(posedge clock); #1;
    in_valid = 1'b0; div_type = 2'($urandom); in1 = $urandom; in2 = $urandom;
    in_tag = 6'($urandom);
  endtask

  task automatic do_op(input string name, input logic [1:0] dt, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] tag,
                       input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res; e.tag = tag; e.lat = lat;
    sb.push_back(e);
    issue(dt, a, b, tag);
    wait_result(name);
    if (out_ready) consume(name);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (out_valid === 1'b1) seen = 1;
    end
    check({name, " no_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] held_out;
    logic [5:0]  held_tag;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    div_type = DIV; in1 = '0; in2 = '0; in_tag = '0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out", out, 32'd0);
    check("rst out_tag", 32'(out_tag), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    do_op("div_100_7",   DIV,  32'd100, 32'd7, 6'd5,  32'd14, 34);
    do_op("rem_100_7",   REM,  32'd100, 32'd7, 6'd6,  32'd2,  34);
    do_op("div_m7_2",    DIV,  32'hFFFFFFF9, 32'd2, 6'd7, 32'hFFFFFFFD, 34);
    do_op("rem_m7_2",    REM,  32'hFFFFFFF9, 32'd2, 6'd8, 32'hFFFFFFFF, 34);
    do_op("divu_big_2",  DIVU, 32'hFFFFFFF9, 32'd2, 6'd9, 32'h7FFFFFFC, 34);
    do_op("div_7_m2",    DIV,  32'd7, 32'hFFFFFFFE, 6'd10, 32'hFFFFFFFD, 34);
    do_op("rem_m7_m2",   REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 6'd11, 32'hFFFFFFFF, 34);
    do_op("div_min_2",   DIV,  32'h80000000, 32'd2, 6'd12, 32'hC0000000, 34);
    do_op("remu_max_7",  REMU, 32'hFFFFFFFF, 32'd7, 6'd13, 32'd3, 34);
    do_op("divu_5_0",    DIVU, 32'd5, 32'd0, 6'd20, 32'hFFFFFFFF, 1);
    do_op("remu_5_0",    REMU, 32'd5, 32'd0, 6'd21, 32'd5, 1);
    do_op("div_m5_0",    DIV,  32'hFFFFFFFB, 32'd0, 6'd22, 32'hFFFFFFFF, 1);
    do_op("rem_m5_0",    REM,  32'hFFFFFFFB, 32'd0, 6'd23, 32'hFFFFFFFB, 1);
    do_op("div_ovf",     DIV,  32'h80000000, 32'hFFFFFFFF, 6'd24, 32'h80000000, 1);
    do_op("rem_ovf",     REM,  32'h80000000, 32'hFFFFFFFF, 6'd25, 32'd0, 1);

    // Back-pressure: hold result for 10 cycles, then release.
    out_ready = 1'b0;
    do_op("bp_div", DIV, 32'd1000, 32'd10, 6'd33, 32'd100, 34);
    held_out = out; held_tag = out_tag;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out", out, held_out);
      check("bp tag", 32'(out_tag), 32'(held_tag));
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    consume("bp_release");

    // Flush at edge +10 of a DIV.
    issue(DIV, 32'd100, 32'd7, 6'd40);
    repeat (8) @(posedge clock);
    @(negedge clock); flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    check("flush in_ready", 32'(in_ready), 32'd1);
    expect_quiet("flush_div", 40);

    // Flush together with in_valid: no accept.
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; div_type = DIVU; in1 = 32'd9; in2 = 32'd3; in_tag = 6'd41;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_acc in_ready", 32'(in_ready), 32'd1);
    expect_quiet("flush_acc", 40);

    // Async reset mid-CALC, between edges.
    issue(DIV, 32'd100, 32'd7, 6'd50);
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("pre_rst in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1; #1;
    check("arst out_valid", 32'(out_valid), 32'd0);
    check("arst in_ready", 32'(in_ready), 32'd1);
    #1 reset = 1'b0;
    do_op("divu_9_3", DIVU, 32'd9, 32'd3, 6'd51, 32'd3, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
